// File: rtl/seg_pair_decoder.sv
// Capture side of a two-digit 7-segment display bus: debounces the raw segment pair,
// decodes it back to a byte and flags codes that are not hex digits.
module seg_pair_decoder #(
  parameter int STABLE_CYCLES  = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg1_in,
  input  logic [6:0] seg2_in,
  input  logic       clear_err,
  output logic [7:0] value_out,
  output logic       valid_out,
  output logic       err_out,
  output logic [7:0] change_cnt
);

  localparam int            CW      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    EMPTY,
    SETTLE,
    HOLD,
    ERR
  } state_e;

  state_e        state_q, state_d;
  logic [13:0]   samp_q, samp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic [7:0]    value_q, value_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic [7:0]    chg_q, chg_d;

  logic [13:0]   samp_in;
  logic [13:0]   code;
  logic [4:0]    dig1, dig2;
  logic          changed, fire, err_set;
  logic [7:0]    pair;

  // Returns {is_hex_digit, nibble} for an active-high {g,f,e,d,c,b,a} code.
  function automatic logic [4:0] decode_digit(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'h3F:   r = 5'h10;
      7'h06:   r = 5'h11;
      7'h5B:   r = 5'h12;
      7'h4F:   r = 5'h13;
      7'h66:   r = 5'h14;
      7'h6D:   r = 5'h15;
      7'h7D:   r = 5'h16;
      7'h07:   r = 5'h17;
      7'h7F:   r = 5'h18;
      7'h6F:   r = 5'h19;
      7'h77:   r = 5'h1A;
      7'h7C:   r = 5'h1B;
      7'h39:   r = 5'h1C;
      7'h5E:   r = 5'h1D;
      7'h79:   r = 5'h1E;
      7'h71:   r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  // Sample filter: the decision fires once, on the edge after the count first saturates.
  always_comb begin
    samp_in = {seg1_in, seg2_in};
    changed = (samp_in != samp_q);
    samp_d  = samp_in;
    fire    = (cnt_q == CNT_MAX) && !done_q;

    if (changed)              cnt_d = CW'(1);
    else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
    else                      cnt_d = cnt_q;

    if (changed)   done_d = 1'b0;
    else if (fire) done_d = 1'b1;
    else           done_d = done_q;
  end

  // NOTE: every output of this block is given a default first so no latch can be inferred.
  always_comb begin
    code    = SEG_ACTIVE_LOW ? ~samp_q : samp_q;
    dig1    = decode_digit(code[13:7]);
    dig2    = decode_digit(code[6:0]);
    pair    = {dig1[3:0], dig2[3:0]};
    state_d = state_q;
    value_d = value_q;
    valid_d = 1'b0;
    chg_d   = chg_q;
    err_set = 1'b0;

    if (fire) begin
      if (dig1[4] && dig2[4]) begin
        // A first publish after reset goes out even when the pair decodes to 0x00.
        if (state_q == EMPTY || pair != value_q) begin
          value_d = pair;
          valid_d = 1'b1;
          chg_d   = chg_q + 8'd1;
        end
        state_d = HOLD;
      end else begin
        err_set = 1'b1;
        state_d = ERR;
      end
    end else if (changed && (state_q == HOLD || state_q == ERR)) begin
      state_d = SETTLE;
    end

    // Set has priority over a simultaneous clear.
    err_d = err_set | (err_q & ~clear_err);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      samp_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      value_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      chg_q   <= '0;
    end else begin
      state_q <= state_d;
      samp_q  <= samp_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      value_q <= value_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      chg_q   <= chg_d;
    end
  end

  assign value_out  = value_q;
  assign valid_out  = valid_q;
  assign err_out    = err_q;
  assign change_cnt = chg_q;

endmodule

// File: tb/tb_seg_pair_decoder.sv
// Scoreboard bench: an active-high and an active-low instance see the same digits;
// a run-length reference model predicts publishes, a negedge monitor checks them.
module tb_seg_pair_decoder;

  localparam int STABLE = 4;
  localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  typedef struct packed {
    logic [7:0] v;
    logic [7:0] c;
  } exp_t;

  typedef struct {
    logic [13:0] samp;
    int          age;
    bit          empty;
    logic [7:0]  value;
    logic [7:0]  cnt;
    logic        err;
  } mdl_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] seg1 = '0;
  logic [6:0] seg2 = '0;
  logic       clr = 1'b0;
  logic [6:0] seg1_n, seg2_n;
  logic [7:0] value_o [2];
  logic [7:0] cnt_o   [2];
  logic       valid_o [2];
  logic       err_o   [2];

  int   total = 0;
  int   bad   = 0;
  mdl_t m [2];
  exp_t q0 [$];
  exp_t q1 [$];

  assign seg1_n = ~seg1;
  assign seg2_n = ~seg2;

  always #5 clk = ~clk;

  seg_pair_decoder #(.STABLE_CYCLES(STABLE), .SEG_ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst(rst), .seg1_in(seg1), .seg2_in(seg2), .clear_err(clr),
    .value_out(value_o[0]), .valid_out(valid_o[0]), .err_out(err_o[0]), .change_cnt(cnt_o[0])
  );

  seg_pair_decoder #(.STABLE_CYCLES(STABLE), .SEG_ACTIVE_LOW(1'b1)) dut_n (
    .clk(clk), .rst(rst), .seg1_in(seg1_n), .seg2_in(seg2_n), .clear_err(clr),
    .value_out(value_o[1]), .valid_out(valid_o[1]), .err_out(err_o[1]), .change_cnt(cnt_o[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  task automatic qpush(input int k, input exp_t e);
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic qpop(input int k, output exp_t e);
    if (k == 0) e = q0.pop_front();
    else        e = q1.pop_front();
  endtask

  task automatic qflush(input int k);
    if (k == 0) q0.delete();
    else        q1.delete();
  endtask

  function automatic logic hex_val(input logic [6:0] c, output logic [3:0] n);
    n = '0;
    for (int i = 0; i < 16; i++) begin
      if (HEX[i] == c) begin
        n = 4'(i);
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic mdl_reset(input int k);
    m[k].samp  = '0;
    m[k].age   = 0;
    m[k].empty = 1'b1;
    m[k].value = '0;
    m[k].cnt   = '0;
    m[k].err   = 1'b0;
    qflush(k);
  endtask

  // age = number of consecutive edges the held pair has been sampled; the pair is judged
  // exactly when age first equals STABLE, on the following edge.
  task automatic mdl_step(input int k, input logic [13:0] raw, input logic c);
    logic [13:0] code;
    logic [3:0]  n1, n2;
    logic        ok1, ok2, set;
    exp_t        e;
    set = 1'b0;
    if (m[k].age == STABLE) begin
      code = (k == 1) ? ~m[k].samp : m[k].samp;
      ok1  = hex_val(code[13:7], n1);
      ok2  = hex_val(code[6:0], n2);
      if (ok1 && ok2) begin
        if (m[k].empty || {n1, n2} != m[k].value) begin
          m[k].value = {n1, n2};
          m[k].cnt   = m[k].cnt + 8'd1;
          e.v = m[k].value;
          e.c = m[k].cnt;
          qpush(k, e);
        end
      end else begin
        set = 1'b1;
      end
      m[k].empty = 1'b0;
    end
    if (set)    m[k].err = 1'b1;
    else if (c) m[k].err = 1'b0;
    if (raw != m[k].samp) begin
      m[k].samp = raw;
      m[k].age  = 1;
    end else if (m[k].age <= STABLE) begin
      m[k].age++;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mdl_reset(0);
      mdl_reset(1);
    end else begin
      mdl_step(0, {seg1, seg2}, clr);
      mdl_step(1, {seg1_n, seg2_n}, clr);
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int   n;
      exp_t e;
      n = qsize(k);
      check($sformatf("valid[%0d]", k), 32'(valid_o[k]), 32'(n != 0));
      if (valid_o[k] && n != 0) begin
        qpop(k, e);
        check($sformatf("pub_value[%0d]", k), 32'(value_o[k]), 32'(e.v));
        check($sformatf("pub_cnt[%0d]", k), 32'(cnt_o[k]), 32'(e.c));
      end else if (n != 0) begin
        qflush(k);
      end
      check($sformatf("err[%0d]", k), 32'(err_o[k]), 32'(m[k].err));
      check($sformatf("value[%0d]", k), 32'(value_o[k]), 32'(m[k].value));
    end
  end

  task automatic drive(input logic [6:0] a, input logic [6:0] b, input logic c, input int n);
    seg1 = a;
    seg2 = b;
    clr  = c;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic expect_out(input string tag, input logic [7:0] v, input logic [7:0] c,
                            input logic e);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s_value[%0d]", tag, k), 32'(value_o[k]), 32'(v));
      check($sformatf("%s_cnt[%0d]", tag, k), 32'(cnt_o[k]), 32'(c));
      check($sformatf("%s_err[%0d]", tag, k), 32'(err_o[k]), 32'(e));
    end
  endtask

  initial begin
    // Reset with random segments applied.
    for (int i = 0; i < 3; i++) drive(7'($urandom), 7'($urandom), 1'b0, 1);
    expect_out("reset", 8'h00, 8'h00, 1'b0);
    for (int k = 0; k < 2; k++) check($sformatf("reset_valid[%0d]", k), 32'(valid_o[k]), 0);
    rst = 1'b0;

    // Basic publish, transient rejection, second value.
    drive(7'h06, 7'h6D, 1'b0, 6);
    expect_out("first", 8'h15, 8'h01, 1'b0);
    drive(7'h06, 7'h7F, 1'b0, 2);
    drive(7'h06, 7'h6D, 1'b0, 6);
    expect_out("transient", 8'h15, 8'h01, 1'b0);
    drive(7'h39, 7'h71, 1'b0, 6);
    expect_out("second", 8'hCF, 8'h02, 1'b0);

    // Invalid code, clear, and set-beats-clear on the same edge.
    drive(7'h39, 7'h00, 1'b0, 6);
    expect_out("invalid", 8'hCF, 8'h02, 1'b1);
    drive(7'h39, 7'h00, 1'b1, 1);
    expect_out("cleared", 8'hCF, 8'h02, 1'b0);
    drive(7'h39, 7'h00, 1'b0, 3);
    expect_out("no_reset", 8'hCF, 8'h02, 1'b0);
    drive(7'h3F, 7'h00, 1'b1, 5);
    expect_out("set_wins", 8'hCF, 8'h02, 1'b1);
    drive(7'h3F, 7'h00, 1'b1, 1);

    // Counter wrap over 256 publishes starting from a fresh reset.
    rst = 1'b1;
    drive(7'h3F, 7'h00, 1'b0, 2);
    rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      if (i % 2 == 0) drive(7'h3F, 7'h3F, 1'b0, 4);
      else            drive(7'h06, 7'h06, 1'b0, 4);
    end
    drive(7'h06, 7'h06, 1'b0, 1);
    expect_out("wrap", 8'h11, 8'h00, 1'b0);
    drive(7'h06, 7'h7F, 1'b0, 2);
    drive(7'h06, 7'h06, 1'b0, 6);
    expect_out("same_again", 8'h11, 8'h00, 1'b0);

    // Random digits, transients, invalid codes and clears.
    for (int i = 0; i < 300; i++) begin
      logic [6:0] a, b;
      a = ($urandom_range(7) != 0) ? HEX[$urandom_range(15)] : 7'($urandom);
      b = ($urandom_range(7) != 0) ? HEX[$urandom_range(15)] : 7'($urandom);
      drive(a, b, ($urandom_range(7) == 0), $urandom_range(1, 7));
    end

    // Reset in the middle of a settle period.
    drive(7'h4F, 7'h4F, 1'b0, 2);
    rst = 1'b1;
    drive(7'h4F, 7'h4F, 1'b0, 1);
    rst = 1'b0;
    drive(7'h4F, 7'h4F, 1'b0, 4);
    expect_out("rst_settle", 8'h00, 8'h00, 1'b0);
    drive(7'h4F, 7'h4F, 1'b0, 2);
    expect_out("rst_publish", 8'h33, 8'h01, 1'b0);

    drive(7'h4F, 7'h4F, 1'b0, 3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
